// File: rtl/carry_ripple_adder3.sv
// Registered unsigned ripple-carry adder: out <= a + b, one cycle of latency.
// The sum is formed by an explicit chain of 1-bit full adders. The carry
// ripples from the LSB to the MSB, and the final carry becomes the result MSB.
module carry_ripple_adder3 #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   out
);

  // c[i] is the carry into bit i. There is no carry-in, so c[0] is tied low.
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = 1'b0;

  // One full adder per bit. Each stage uses the carry of the stage below it,
  // so the chain is a true ripple with no lookahead.
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    logic p;
    assign p        = a[i] ^ b[i];
    assign s[i]     = p ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & p);
  end

  // Result register with synchronous reset. The final carry forms the MSB.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) out <= '0;
    else     out <= {c[WIDTH], s};
  end

endmodule

// File: tb/tb_carry_ripple_adder3.sv
// Directed self-checking bench for carry_ripple_adder3 (WIDTH=3).
// Each step drives one operand pair on the falling edge and checks out #1 after
// the next rising edge. Expected sums are written by hand, or derived as plain
// unsigned arithmetic for the seeded random pairs.
module tb_carry_ripple_adder3;

  localparam int WIDTH = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   out;

  int total = 0;
  int bad   = 0;
  bit seen [0:15];

  carry_ripple_adder3 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .out (out)
  );

  // 10 ns clock period.
  always #5 clk = ~clk;

  // Stop the run if the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("FAIL %s: observed=%0d required=%0d", tag, observed, expected);
    end
  endtask

  // Drive one cycle of stimulus, then check the registered result after the edge.
  task automatic step(input string tag, input logic r, input logic [WIDTH-1:0] va,
                      input logic [WIDTH-1:0] vb, input logic [WIDTH:0] exp_out);
    @(negedge clk);
    rst = r;
    a   = va;
    b   = vb;
    @(posedge clk);
    #1;
    check(tag, 16'(out), 16'(exp_out));
    if (out <= 4'd14 && !$isunknown(out)) seen[out] = 1'b1;
  endtask

  initial begin
    int unsigned seed_dummy;
    logic [WIDTH-1:0] ra, rb;
    logic [WIDTH:0]   rsum;

    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    rst = 1'b1;
    a   = '0;
    b   = '0;

    // Hold reset for two edges while the operands would give 14.
    step("rst_edge0", 1'b1, 3'd7, 3'd7, 4'd0);
    step("rst_edge1", 1'b1, 3'd7, 3'd7, 4'd0);
    step("rel_7p7",   1'b0, 3'd7, 3'd7, 4'd14);

    // Boundary and carry-ripple vectors.
    step("zero",  1'b0, 3'd0, 3'd0, 4'd0);
    step("7p1",   1'b0, 3'd7, 3'd1, 4'd8);
    step("4p4",   1'b0, 3'd4, 3'd4, 4'd8);
    step("3p5",   1'b0, 3'd3, 3'd5, 4'd8);
    step("neg3x2", 1'b0, 3'd5, 3'd5, 4'd10);

    // Twenty seeded pseudo-random pairs, one per cycle.
    seed_dummy = $urandom(10);
    for (int i = 0; i < 20; i++) begin
      ra   = WIDTH'($urandom % 8);
      rb   = WIDTH'($urandom % 8);
      rsum = {1'b0, ra} + {1'b0, rb};
      step($sformatf("rnd%0d", i), 1'b0, ra, rb, rsum);
    end

    // Back-to-back max and zero operands with no idle cycle between them.
    step("b2b_max",  1'b0, 3'd7, 3'd7, 4'd14);
    step("b2b_zero", 1'b0, 3'd0, 3'd0, 4'd0);

    // Reset for one cycle during a stream. The pending sum is dropped and then resumes.
    step("mid_rst",  1'b1, 3'd6, 3'd5, 4'd0);
    step("post_rst", 1'b0, 3'd6, 3'd5, 4'd11);

    // Sweep so every sum from 0 to 14 occurs: i+0 gives 0..7, 7+i gives 7..14.
    for (int i = 0; i < 8; i++) step($sformatf("sw_a%0d", i), 1'b0, WIDTH'(i), 3'd0, 4'(i));
    for (int i = 0; i < 8; i++) step($sformatf("sw_b%0d", i), 1'b0, 3'd7, WIDTH'(i), 4'(7 + i));

    // Scoreboard: each sum value 0..14 must have appeared on out.
    for (int v = 0; v <= 14; v++) check($sformatf("seen%0d", v), 16'(seen[v]), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/carry_ripple_adder3.md
Name: carry_ripple_adder3

Overview:
- Registered, unsigned ripple-carry adder. Sums two WIDTH-bit operands into a WIDTH+1-bit result.
- Built as an explicit chain of 1-bit full adders, with the carry propagating LSB to MSB. No carry-lookahead and no synthesis "+" operator on the full width.
- Used as a small arithmetic leaf in datapaths. The default configuration is a 3-bit adder with a 4-bit sum.

Parameters:
- WIDTH, 3, operand width in bits (≥1); result width is WIDTH+1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- out  output  WIDTH+1  registered sum a+b; the MSB is the final carry-out.

Behaviour:
- One clock; all state updates on the rising edge of clk.
- Reset is synchronous and active-high. When rst=1 at a rising edge, out is forced to 0 on that edge, regardless of a/b.
- Reset value of out is all zeros. Before the first reset edge, out is undefined.
- Datapath:
  - Bit i uses a full adder: s[i] = a[i]^b[i]^c[i]; c[i+1] = a[i]&b[i] | c[i]&(a[i]^b[i]).
  - c[0] = 0. The carry chain is built with a generate loop of full-adder instances or equivalent per-bit logic.
  - The combinational sum {c[WIDTH], s[WIDTH-1:0]} is captured into the out register.
- Latency: exactly 1 cycle. Operands sampled at edge N appear on out after edge N and hold until edge N+1.
- Throughput: one new operand pair per cycle. There is no handshake; every cycle is a valid sample.
- Arithmetic:
  - Unsigned only; no overflow is possible, since max (2^WIDTH-1)*2 fits in WIDTH+1 bits.
  - Operands are interpreted purely as bit patterns. Truncated negative stimulus, e.g. -3 in 3 bits = 5, is summed as unsigned.
- Boundaries:
  - 0+0 → 0.
  - max+max → 2^(WIDTH+1)-2, i.e. 14 for WIDTH=3.
  - max+1 sets only the MSB, i.e. 8.
  - The full carry ripple through all bits must settle within one clock period.
- Reset mid-operation: a pending sum is discarded; out=0 on the reset edge. Normal sampling resumes on the first edge with rst=0.
- Inputs containing X/Z propagate X to out. No special handling.
- No internal state other than the out register.

Test Plan:
- rst=1 for 2 cycles with a=7, b=7 → out=0 on both edges. Release rst → out=14 after the next edge.
- a=0, b=0 → out=0 one cycle later.
- a=7, b=1 → out=8, a full carry ripple. a=4, b=4 → out=8. a=3, b=5 → out=8.
- 20 pseudo-random pairs (seed 10, values mod 8), one per cycle → each out equals the unsigned sum of the pair sampled one cycle earlier. A scoreboard checks every value from 0 to 14 seen.
- Back-to-back a=7/b=7 then a=0/b=0 → out 14 then 0 on consecutive cycles, with no bubble.
- Assert rst for one cycle while streaming a=6, b=5 → out=0 on that edge, then 11 on the following edge.
